// File: rtl/alu_defines.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_defines;

    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpSub = 4'd3;
    localparam logic [3:0] OpAnd = 4'd4;
    localparam logic [3:0] OpOr  = 4'd5;
    localparam logic [3:0] OpNor = 4'd6;
    localparam logic [3:0] OpXor = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH steps.
// done is high during the final step; product carries the finished value in that cycle.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;   // {partial high, remaining multiplier bits}
    logic [CntW-1:0]    count_q;
    logic               busy_q;
    logic [WIDTH:0]     sum;

    // One shift-add step: add multiplicand to the high half when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
              (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    end

    assign product = {sum, prod_q[WIDTH-1:1]};
    assign done    = busy_q && (count_q == CntW'(1));

    // Load operands on start, then step until the bit counter runs out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            count_q <= CntW'(WIDTH);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q  <= product;
            count_q <= count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle logic/arith ops, iterative MUL.
module alu_seq
    import alu_defines::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    alu_state_e         state_q;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   out_hi_q;
    logic               overflow_q;
    logic               zero_q;
    logic               negative_q;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (control == OpMul);

    assign out_valid = (state_q == StDone);
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result for every non-MUL opcode; undefined opcodes yield zero.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (control)
            OpAdd: begin
                alu_res = A + B;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OpSub: begin
                alu_res = A - B;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OpAnd:   alu_res = A & B;
            OpOr:    alu_res = A | B;
            OpNor:   alu_res = ~(A | B);
            OpXor:   alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

    // Control FSM with registered result and flags, held while DONE awaits out_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            out_q      <= '0;
            out_hi_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (control == OpMul) begin
                            state_q <= StMul;
                        end else begin
                            state_q    <= StDone;
                            out_q      <= alu_res;
                            out_hi_q   <= '0;
                            overflow_q <= alu_ovf;
                            zero_q     <= (alu_res == '0);
                            negative_q <= alu_res[WIDTH-1];
                        end
                    end else if ((state_q == StDone) && out_ready) begin
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        state_q    <= StDone;
                        out_q      <= mul_product[WIDTH-1:0];
                        out_hi_q   <= mul_product[2*WIDTH-1:WIDTH];
                        overflow_q <= (mul_product[2*WIDTH-1:WIDTH] != '0);
                        zero_q     <= (mul_product == '0);
                        negative_q <= mul_product[2*WIDTH-1];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have port: clock  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: A  input  WIDTH  operand A.
REQ-007 SHALL have port: B  input  WIDTH  operand B.
REQ-008 SHALL have port: control  input  4  opcode.
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port: out  output  WIDTH  result; low half for MUL.
REQ-012 SHALL have port: out_hi  output  WIDTH  MUL high half; 0 for all other ops.
REQ-013 SHALL have port: overflow, zero, negative  output  1 each  result flags.

Function
REQ-014 Opcodes: ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7, MUL=8 (unsigned).
REQ-015 Request accepted on a rising edge with in_valid && in_ready; A, B, control captured then.
REQ-016 States: IDLE, MUL, DONE.
REQ-017 IDLE: in_ready=1. Accept of a non-MUL op -> DONE; result registered that edge, so out_valid rises 1 cycle after accept.
REQ-018 IDLE: accept of MUL -> MUL; shift-add, one multiplier bit per cycle, WIDTH cycles, then -> DONE; out_valid rises exactly WIDTH+1 cycles after accept.
REQ-019 MUL: in_ready=0, out_valid=0; in_valid ignored.
REQ-020 DONE: out_valid=1; out, out_hi and flags held stable until out_valid && out_ready.
REQ-021 DONE with out_ready=1: in_ready=1; a same-cycle accept loads the next op (non-MUL -> DONE, MUL -> MUL); no accept -> IDLE.
REQ-022 DONE with out_ready=0: in_ready=0.
REQ-023 ADD/SUB: modulo 2^WIDTH; overflow = signed two's-complement overflow.
REQ-024 AND/OR/NOR/XOR: bitwise; overflow=0.
REQ-025 MUL: {out_hi,out} = full 2*WIDTH-bit product; overflow = (out_hi != 0).
REQ-026 zero: non-MUL -> out==0; MUL -> {out_hi,out}==0.
REQ-027 negative: non-MUL -> out[WIDTH-1]; MUL -> out_hi[WIDTH-1].
REQ-028 Undefined opcodes (0,1,9..15): accepted, 1-cycle latency; out=0, out_hi=0, zero=1, overflow=0, negative=0.

Reset
REQ-029 reset low SHALL immediately force state=IDLE, out_valid=0, out=0, out_hi=0, overflow=0, zero=0, negative=0, in_ready=1, regardless of clock.
REQ-030 Reset asserted mid-MUL or in DONE SHALL abandon the operation; no result appears after release.
REQ-031 First accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 Opcode constants and state encoding SHALL live in a shared package/header, alu_defines, reused by the bench.
REQ-033 Iterative multiplier SHALL be one sub-module, alu_seq_mul (start, operands, done, 2*WIDTH product); all other logic in alu_seq.

Verification (WIDTH=32)
REQ-034 ADD A=8, B=4 -> out=12, overflow=0, zero=0, negative=0, out_valid 1 cycle after accept.
REQ-035 SUB A=2, B=5 -> out=0xFFFFFFFD, negative=1; ADD 0x7FFFFFFF+1 -> out=0x80000000, overflow=1, negative=1; XOR 1,1 -> out=0, zero=1; NOR 0,1 -> out=0xFFFFFFFE.
REQ-036 MUL A=0x00010000, B=0x00010000 -> out=0, out_hi=1, overflow=1, zero=0, out_valid exactly 33 cycles after accept; MUL 7*6 -> out=42, out_hi=0, overflow=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 with new ADD 1+1 in_valid same cycle -> accepted, out=2 next cycle.
REQ-038 Reset low 10 cycles into MUL -> out_valid=0, in_ready=1 at once; after release no stale result; ADD 3+4 -> out=7.
REQ-039 Opcode 15 with A=5, B=5 -> out=0, zero=1, 1-cycle latency.
